// File: rtl/q_pkg.sv
// q_pkg: shared defaults and credit-count sizing for the queue read-side prefetch stage
package q_pkg;
    localparam int RAM_RD_LAT = 1;  // read latency of the backing RAM macro
    localparam int DEF_BUF_N = RAM_RD_LAT + 2;
    function automatic int cnt_width(input int buf_n);
        return $clog2(buf_n + 1);
    endfunction
    typedef logic [cnt_width(DEF_BUF_N)-1:0] cnt_t;
endpackage

// File: rtl/queue_rd_buf.sv
// queue_rd_buf: BUF_N-entry in-order register FIFO; pointers wrap by explicit compare
module queue_rd_buf
    import q_pkg::*;
#(
    parameter int W = 32,
    parameter int BUF_N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid
);
    localparam int PTR_W = $clog2(BUF_N);
    localparam int OCC_W = cnt_width(BUF_N);
    logic [W-1:0] mem_q [BUF_N];
    logic [W-1:0] mem_d [BUF_N];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // BUF_N need not be a power of two, so wrap on the last index
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_N - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d = occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
        rd_data = mem_q[rd_ptr_q];
        rd_valid = occ_q != '0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/queue_rd_prefetch.sv
// queue_rd_prefetch: pops the queue ahead of demand so RAM read latency is hidden from the consumer
module queue_rd_prefetch
    import q_pkg::*;
#(
    parameter int W = 32,
    parameter int RD_LAT = RAM_RD_LAT,
    parameter int BUF_N = RD_LAT + 2,
    parameter int CNT_W = cnt_width(BUF_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_empty,
    output logic             o_pop,
    input  logic [W-1:0]     i_rd_data,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt
);
    logic [RD_LAT-1:0] infl_q, infl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic buf_valid, accept;

    // credits cover buffered plus in-flight words, so a pop never overruns the buffer
    always_comb begin
        o_pop = !rst && !i_empty && (cnt_q < CNT_W'(BUF_N));
        o_valid = !rst && buf_valid;
        o_cnt = rst ? '0 : cnt_q;
        accept = o_valid && i_ready;
        infl_d = RD_LAT'({infl_q, o_pop});
        cnt_d = cnt_q + CNT_W'(o_pop) - CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q <= '0;
            cnt_q <= '0;
        end else begin
            infl_q <= infl_d;
            cnt_q <= cnt_d;
        end
    end

    queue_rd_buf #(.W(W), .BUF_N(BUF_N)) u_buf (
        .clk(clk),
        .rst(rst),
        .wr_en(infl_q[RD_LAT-1]),
        .wr_data(i_rd_data),
        .rd_en(accept),
        .rd_data(o_data),
        .rd_valid(buf_valid)
    );
endmodule
